rf_wr_sched: RTL

- Write scheduler for the 64x32 stack-cache register file, which has 3 read ports and 2 write ports (D, E).
- The register file writes on the rising edge of each write enable, so a port must see its enable low between two writes.
- This block takes writes from two pipeline sources and the dribbler, buffers them in order in a small FIFO, and issues them to ports D and E with correct enable pulses.
- It also flags read addresses that still have a write pending in the FIFO, so the pipeline can hold.

---
 rtl/rf_wr_sched.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/rf_wr_sched.sv
// rf_wr_sched: write scheduler for the 64x32 stack-cache register file.
// Collects writes from two pipeline sources and the dribbler into an
// in-order queue and issues them to write ports D and E as single-cycle
// enable pulses, each followed by a mandatory low recovery cycle.
// Also reports read addresses that still have a write waiting in the queue.
module rf_wr_sched #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        wr0_req,
    input  logic [5:0]  wr0_addr,
    input  logic [31:0] wr0_data,
    input  logic        wr1_req,
    input  logic [5:0]  wr1_addr,
    input  logic [31:0] wr1_data,
    input  logic        drb_req,
    input  logic [5:0]  drb_addr,
    input  logic [31:0] drb_data,
    output logic        drb_ack,
    output logic        wr_stall,
    output logic        ovf_err,
    input  logic [5:0]  add_a,
    input  logic [5:0]  add_b,
    input  logic [5:0]  add_c,
    output logic [2:0]  rd_haz,
    output logic        we_d,
    output logic [5:0]  add_d,
    output logic [31:0] di_d,
    output logic        we_e,
    output logic [5:0]  add_e,
    output logic [31:0] di_e,
    output logic        idle
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 2);

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t             r_mem [DEPTH];
    logic [PTR_W-1:0]   r_rdPtr;
    logic [PTR_W-1:0]   r_wrPtr;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;
    logic               r_weD;
    logic [5:0]         r_addD;
    logic [31:0]        r_diD;
    logic               r_weE;
    logic [5:0]         r_addE;
    logic [31:0]        r_diE;

    logic [CNT_W-1:0]   w_space;
    logic               w_acc0;
    logic               w_acc1;
    logic               w_drop;
    logic               w_drbAck;
    entry_t             w_enq0;
    entry_t             w_enq1;
    logic [1:0]         w_numEnq;
    entry_t             w_head;
    entry_t             w_next;
    logic               w_dispD;
    logic               w_dispE;
    entry_t             w_dataD;
    entry_t             w_dataE;
    logic [1:0]         w_numDisp;
    logic [PTR_W-1:0]   w_off [DEPTH];
    logic [DEPTH-1:0]   w_valid;
    logic [2:0]         w_haz;

    // Admission: space is judged on the registered count only, so a
    // pipeline that honours wr_stall can never lose a write.
    assign w_space  = FULL_CNT - r_count;
    assign w_acc0   = wr0_req && (w_space != '0);
    assign w_acc1   = wr1_req && (w_space > CNT_W'(w_acc0));
    assign w_drop   = (wr0_req && !w_acc0) || (wr1_req && !w_acc1);
    assign w_drbAck = drb_req && !wr0_req && !wr1_req && (r_count < FULL_CNT);

    // Pack accepted requests, oldest first, into up to two enqueue slots.
    always_comb begin
        w_enq0   = '0;
        w_enq1   = '0;
        w_numEnq = 2'd0;
        if (w_acc0) begin
            w_enq0 = '{addr: wr0_addr, data: wr0_data};
            if (w_acc1) begin
                w_enq1   = '{addr: wr1_addr, data: wr1_data};
                w_numEnq = 2'd2;
            end else begin
                w_numEnq = 2'd1;
            end
        end else if (w_acc1) begin
            w_enq0   = '{addr: wr1_addr, data: wr1_data};
            w_numEnq = 2'd1;
        end else if (w_drbAck) begin
            w_enq0   = '{addr: drb_addr, data: drb_data};
            w_numEnq = 2'd1;
        end
    end

    assign w_head = r_mem[r_rdPtr];
    assign w_next = r_mem[r_rdPtr + PTR_W'(1)];

    // Pick up to two head entries for whichever ports are out of recovery;
    // a same-address second entry waits so the older value lands first.
    always_comb begin
        w_dispD   = 1'b0;
        w_dispE   = 1'b0;
        w_dataD   = w_head;
        w_dataE   = w_head;
        w_numDisp = 2'd0;
        if (r_count != '0) begin
            if (!r_weD) begin
                w_dispD   = 1'b1;
                w_numDisp = 2'd1;
                if (!r_weE && (r_count >= CNT_W'(2)) && (w_next.addr != w_head.addr)) begin
                    w_dispE   = 1'b1;
                    w_dataE   = w_next;
                    w_numDisp = 2'd2;
                end
            end else if (!r_weE) begin
                w_dispE   = 1'b1;
                w_numDisp = 2'd1;
            end
        end
    end

    // Queue storage: needs no reset because validity comes from the count.
    always_ff @(posedge clk) begin
        if (w_numEnq != 2'd0) begin
            r_mem[r_wrPtr] <= w_enq0;
        end
        if (w_numEnq == 2'd2) begin
            r_mem[r_wrPtr + PTR_W'(1)] <= w_enq1;
        end
    end

    // Pointers, occupancy, sticky overflow flag and the registered port drive.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_weD   <= 1'b0;
            r_addD  <= '0;
            r_diD   <= '0;
            r_weE   <= 1'b0;
            r_addE  <= '0;
            r_diE   <= '0;
        end else begin
            r_wrPtr <= r_wrPtr + PTR_W'(w_numEnq);
            r_rdPtr <= r_rdPtr + PTR_W'(w_numDisp);
            r_count <= r_count + CNT_W'(w_numEnq) - CNT_W'(w_numDisp);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end
            r_weD <= w_dispD;
            if (w_dispD) begin
                r_addD <= w_dataD.addr;
                r_diD  <= w_dataD.data;
            end
            r_weE <= w_dispE;
            if (w_dispE) begin
                r_addE <= w_dataE.addr;
                r_diE  <= w_dataE.data;
            end
        end
    end

    // Mark which storage slots currently hold queued (not yet issued) writes.
    always_comb begin
        w_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off[i]   = PTR_W'(i) - r_rdPtr;
            w_valid[i] = ({1'b0, w_off[i]} < r_count);
        end
    end

    // Compare each read address against every queued write address.
    always_comb begin
        w_haz = 3'b000;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) begin
                if (r_mem[i].addr == add_a) w_haz[0] = 1'b1;
                if (r_mem[i].addr == add_b) w_haz[1] = 1'b1;
                if (r_mem[i].addr == add_c) w_haz[2] = 1'b1;
            end
        end
    end

    assign drb_ack  = w_drbAck;
    assign wr_stall = (r_count > STALL_CNT);
    assign ovf_err  = r_ovf;
    assign rd_haz   = w_haz;
    assign we_d     = r_weD;
    assign add_d    = r_addD;
    assign di_d     = r_diD;
    assign we_e     = r_weE;
    assign add_e    = r_addE;
    assign di_e     = r_diE;
    assign idle     = (r_count == '0) && !r_weD && !r_weE;

endmodule
